// File: rtl/shift_register_set_if.sv
// Signal bundle for the three shift/storage channels of shift_register_set.
// The master side drives serial/parallel inputs and loads; the slave side returns register contents.
interface shift_register_set_if #(
  parameter int WIDTH = 4
);

  logic             sipo_sin;
  logic [WIDTH-1:0] sipo_q;

  logic [WIDTH-1:0] piso_d;
  logic             piso_load;
  logic             piso_sout;

  logic [WIDTH-1:0] pipo_d;
  logic             pipo_load;
  logic [WIDTH-1:0] pipo_q;

  modport master (
    output sipo_sin,
    output piso_d,
    output piso_load,
    output pipo_d,
    output pipo_load,
    input  sipo_q,
    input  piso_sout,
    input  pipo_q
  );

  modport slave (
    input  sipo_sin,
    input  piso_d,
    input  piso_load,
    input  pipo_d,
    input  pipo_load,
    output sipo_q,
    output piso_sout,
    output pipo_q
  );

endinterface

// File: rtl/shift_register_set.sv
// Three independent WIDTH-bit registers sharing clk/rst: serial-in/parallel-out,
// parallel-in/serial-out (MSB first, zero fill) and a loadable parallel holding register.
module shift_register_set #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_register_set_if.slave  bus
);

  if (WIDTH < 2) begin : g_width_check
    $error("shift_register_set: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] preg;
  logic [WIDTH-1:0] qreg;

  // SIPO: shifts on every edge, newest bit enters at the LSB.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; reset is asynchronous, so it clears state without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else begin
      sreg <= {sreg[WIDTH-2:0], bus.sipo_sin};
    end
  end

  // PISO: load wins over shift, so a reload mid-word restarts the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preg <= '0;
    end else if (bus.piso_load) begin
      preg <= bus.piso_d;
    end else begin
      preg <= {preg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qreg <= '0;
    end else if (bus.pipo_load) begin
      qreg <= bus.pipo_d;
    end
  end

  // Outputs come straight from the registers; no input reaches an output combinationally.
  assign bus.sipo_q    = sreg;
  assign bus.piso_sout = preg[WIDTH-1];
  assign bus.pipo_q    = qreg;

endmodule

// File: tb/tb_shift_register_set.sv
// Directed bench for shift_register_set (WIDTH=4): table of per-edge vectors with
// hand-computed results, plus reset and channel-independence sequences.
module tb_shift_register_set;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  shift_register_set_if #(.WIDTH(W)) bus ();

  shift_register_set #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sin;
    logic         piso_load;
    logic [W-1:0] piso_d;
    logic         pipo_load;
    logic [W-1:0] pipo_d;
    logic [W-1:0] exp_sipo;
    logic         exp_sout;
    logic [W-1:0] exp_pipo;
  } vec_t;

  vec_t vecs [13];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_sipo,
                           input logic e_sout, input logic [W-1:0] e_pipo);
    check({tag, " sipo_q"},    32'(bus.sipo_q),    32'(e_sipo));
    check({tag, " piso_sout"}, 32'(bus.piso_sout), 32'(e_sout));
    check({tag, " pipo_q"},    32'(bus.pipo_q),    32'(e_pipo));
  endtask

  task automatic drive(input logic sin, input logic pl, input logic [W-1:0] pd,
                       input logic ql, input logic [W-1:0] qd);
    bus.sipo_sin  = sin;
    bus.piso_load = pl;
    bus.piso_d    = pd;
    bus.pipo_load = ql;
    bus.pipo_d    = qd;
  endtask

  // Drive at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic sin, input logic pl, input logic [W-1:0] pd,
                      input logic ql, input logic [W-1:0] qd);
    @(negedge clk);
    drive(sin, pl, pd, ql, qd);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sipo_model;
  logic [7:0]   pattern;

  initial begin
    // Vectors start from the all-zero reset state and run all channels together.
    vecs[0]  = '{1'b1, 1'b1, 4'b1010, 1'b1, 4'b1100, 4'b0001, 1'b1, 4'b1100};
    vecs[1]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 4'b0011, 1'b0, 4'b1100};
    vecs[2]  = '{1'b0, 1'b0, 4'b1111, 1'b0, 4'b0011, 4'b0110, 1'b1, 4'b1100};
    vecs[3]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, 4'b1101, 1'b0, 4'b1100};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0011, 4'b1010, 1'b0, 4'b0011};
    vecs[5]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0011};
    vecs[6]  = '{1'b1, 1'b1, 4'b1010, 1'b0, 4'b0000, 4'b1001, 1'b1, 4'b0011};
    vecs[7]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0011, 1'b0, 4'b0011};
    vecs[8]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0110, 1'b1, 4'b0011};
    vecs[9]  = '{1'b0, 1'b1, 4'b0110, 1'b0, 4'b0000, 4'b1100, 1'b0, 4'b0011};
    vecs[10] = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b1001, 1'b1, 4'b0011};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0011};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 4'b0011};

    drive(1'b0, 1'b0, '0, 1'b0, '0);

    // Power-up reset, asserted away from any clock edge.
    #2 rst = 1'b1;
    #1 check_all("por", 4'b0000, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Load every channel nonzero, then reset asynchronously between edges.
    step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1010);
    check_all("preload", 4'b0001, 1'b1, 4'b1010);
    @(negedge clk);
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
    #1 check_all("async_rst", 4'b0000, 1'b0, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_all("rst_held", 4'b0000, 1'b0, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111);
    @(posedge clk);
    #1 check_all("quiet_after_rst", 4'b0000, 1'b0, 4'b0000);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].sin, vecs[i].piso_load, vecs[i].piso_d, vecs[i].pipo_load, vecs[i].pipo_d);
      check_all($sformatf("vec%0d", i), vecs[i].exp_sipo, vecs[i].exp_sout, vecs[i].exp_pipo);
    end

    // Reset mid-operation: discard partial words, then restart from zero.
    step(1'b1, 1'b1, 4'b1111, 1'b1, 4'b1010);
    check_all("mid_load", 4'b1001, 1'b1, 4'b1010);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    check_all("mid_shift1", 4'b0011, 1'b1, 4'b1010);
    step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    check_all("mid_shift2", 4'b0111, 1'b1, 4'b1010);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1 check_all("mid_rst", 4'b0000, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 4'b1111, 1'b0, 4'b1111);
    @(posedge clk);
    #1 check_all("restart1", 4'b0001, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
    check_all("restart2", 4'b0010, 1'b0, 4'b0000);

    // Independence: SIPO shifts a known pattern while the other loads toggle.
    sipo_model = 4'b0010;
    pattern    = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) begin
      step(pattern[i], 1'($urandom_range(0, 1)), 4'($urandom),
           1'($urandom_range(0, 1)), 4'($urandom));
      sipo_model = {sipo_model[W-2:0], pattern[i]};
      check($sformatf("indep%0d sipo_q", 7 - i), 32'(bus.sipo_q), 32'(sipo_model));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
